// File: rtl/multi_sprite_hit.sv
// rtl/multi_sprite_hit.sv - pipelined multi-sprite hit tester for a streamed raster
module multi_sprite_hit #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_W    = 24,
  parameter int SPRITE_H    = 24,
  parameter int COORD_W     = 10,
  parameter int ADDR_W      = 19,
  localparam int IDX_W      = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
  localparam int OFFX_W     = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1,
  localparam int OFFY_W     = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1
) (
  input  logic               m_clk,
  input  logic               reset,
  input  logic               pix_valid,
  input  logic               pix_start,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [COORD_W-1:0] cfg_x,
  input  logic [COORD_W-1:0] cfg_y,
  input  logic               cfg_en,
  output logic               out_valid,
  output logic               hit,
  output logic [IDX_W-1:0]   hit_idx,
  output logic [OFFX_W-1:0]  off_x,
  output logic [OFFY_W-1:0]  off_y,
  output logic [ADDR_W-1:0]  out_addr
);

  // Raster position of the next pixel to be accepted
  logic [COORD_W-1:0] r_x, r_y;
  logic [ADDR_W-1:0]  r_addr;

  // Pending (shadow) and active sprite configuration
  logic [COORD_W-1:0]   r_pend_x [NUM_SPRITES];
  logic [COORD_W-1:0]   r_pend_y [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] r_pend_en;
  logic [COORD_W-1:0]   r_act_x [NUM_SPRITES];
  logic [COORD_W-1:0]   r_act_y [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] r_act_en;

  // Stage 1 registers
  logic                 r_s1_valid;
  logic [NUM_SPRITES-1:0] r_s1_hit;
  logic [OFFX_W-1:0]    r_s1_dx [NUM_SPRITES];
  logic [OFFY_W-1:0]    r_s1_dy [NUM_SPRITES];
  logic [ADDR_W-1:0]    r_s1_addr;

  // Stage 2 (output) registers
  logic                 r_out_valid;
  logic                 r_out_hit;
  logic [IDX_W-1:0]     r_out_idx;
  logic [OFFX_W-1:0]    r_out_dx;
  logic [OFFY_W-1:0]    r_out_dy;
  logic [ADDR_W-1:0]    r_out_addr;

  logic                 w_commit;
  logic [COORD_W-1:0]   w_px, w_py, w_nx, w_ny;
  logic [ADDR_W-1:0]    w_paddr, w_naddr;
  logic                 w_last_col, w_last_row;

  logic [COORD_W-1:0]   w_pend_x [NUM_SPRITES];
  logic [COORD_W-1:0]   w_pend_y [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] w_pend_en;
  logic [COORD_W-1:0]   w_act_x [NUM_SPRITES];
  logic [COORD_W-1:0]   w_act_y [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] w_act_en;

  logic [NUM_SPRITES-1:0] w_in;
  logic [OFFX_W-1:0]    w_dx [NUM_SPRITES];
  logic [OFFY_W-1:0]    w_dy [NUM_SPRITES];
  logic [COORD_W:0]     w_lo_x, w_hi_x, w_lo_y, w_hi_y;

  logic                 w_enc_hit;
  logic [IDX_W-1:0]     w_enc_idx;
  logic [OFFX_W-1:0]    w_enc_dx;
  logic [OFFY_W-1:0]    w_enc_dy;

  assign w_commit = pix_valid & pix_start;

  // Current pixel coordinate (frame start forces origin) and its raster successor
  always_comb begin
    w_px       = pix_start ? '0 : r_x;
    w_py       = pix_start ? '0 : r_y;
    w_paddr    = pix_start ? '0 : r_addr;
    w_last_col = (w_px == COORD_W'(H_RES - 1));
    w_last_row = (w_py == COORD_W'(V_RES - 1));
    w_nx       = w_last_col ? '0 : w_px + COORD_W'(1);
    w_ny       = w_last_col ? (w_last_row ? '0 : w_py + COORD_W'(1)) : w_py;
    w_naddr    = (w_last_col && w_last_row) ? '0 : w_paddr + ADDR_W'(1);
  end

  // Advance the raster counters on each accepted pixel
  always_ff @(posedge m_clk) begin
    if (reset) begin
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= '0;
    end else if (pix_valid) begin
      r_x    <= w_nx;
      r_y    <= w_ny;
      r_addr <= w_naddr;
    end
  end

  // Post-write pending values, and active values as seen by the current pixel
  always_comb begin
    for (int i = 0; i < NUM_SPRITES; i++) begin
      w_pend_x[i]  = r_pend_x[i];
      w_pend_y[i]  = r_pend_y[i];
      w_pend_en[i] = r_pend_en[i];
      if (cfg_we && (cfg_idx == IDX_W'(i))) begin
        w_pend_x[i]  = cfg_x;
        w_pend_y[i]  = cfg_y;
        w_pend_en[i] = cfg_en;
      end
      w_act_x[i]  = w_commit ? w_pend_x[i]  : r_act_x[i];
      w_act_y[i]  = w_commit ? w_pend_y[i]  : r_act_y[i];
      w_act_en[i] = w_commit ? w_pend_en[i] : r_act_en[i];
    end
  end

  // Hold pending writes and commit them to the active set at frame start
  always_ff @(posedge m_clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        r_pend_x[i] <= '0;
        r_pend_y[i] <= '0;
        r_act_x[i]  <= '0;
        r_act_y[i]  <= '0;
      end
      r_pend_en <= '0;
      r_act_en  <= '0;
    end else begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        r_pend_x[i] <= w_pend_x[i];
        r_pend_y[i] <= w_pend_y[i];
        r_act_x[i]  <= w_act_x[i];
        r_act_y[i]  <= w_act_y[i];
      end
      r_pend_en <= w_pend_en;
      r_act_en  <= w_act_en;
    end
  end

  // Per-sprite inclusive bounds test in one extra bit so right/bottom edges clip
  always_comb begin
    w_in   = '0;
    w_lo_x = '0;
    w_hi_x = '0;
    w_lo_y = '0;
    w_hi_y = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      w_lo_x  = {1'b0, w_act_x[i]};
      w_hi_x  = w_lo_x + (COORD_W+1)'(SPRITE_W - 1);
      w_lo_y  = {1'b0, w_act_y[i]};
      w_hi_y  = w_lo_y + (COORD_W+1)'(SPRITE_H - 1);
      w_in[i] = w_act_en[i] &&
                ({1'b0, w_px} >= w_lo_x) && ({1'b0, w_px} <= w_hi_x) &&
                ({1'b0, w_py} >= w_lo_y) && ({1'b0, w_py} <= w_hi_y);
      w_dx[i] = OFFX_W'(w_px - w_act_x[i]);
      w_dy[i] = OFFY_W'(w_py - w_act_y[i]);
    end
  end

  // Stage 1: capture compare bits, offsets and address of the accepted pixel
  always_ff @(posedge m_clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_hit   <= '0;
      r_s1_addr  <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        r_s1_dx[i] <= '0;
        r_s1_dy[i] <= '0;
      end
    end else begin
      r_s1_valid <= pix_valid;
      if (pix_valid) begin
        r_s1_hit  <= w_in;
        r_s1_addr <= w_paddr;
        for (int i = 0; i < NUM_SPRITES; i++) begin
          r_s1_dx[i] <= w_dx[i];
          r_s1_dy[i] <= w_dy[i];
        end
      end
    end
  end

  // Fixed-priority encode: scanning downward leaves the lowest covering index
  always_comb begin
    w_enc_hit = 1'b0;
    w_enc_idx = '0;
    w_enc_dx  = '0;
    w_enc_dy  = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (r_s1_hit[i]) begin
        w_enc_hit = 1'b1;
        w_enc_idx = IDX_W'(i);
        w_enc_dx  = r_s1_dx[i];
        w_enc_dy  = r_s1_dy[i];
      end
    end
  end

  // Stage 2: register the encoded result; data holds while no pixel is reported
  always_ff @(posedge m_clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_hit   <= 1'b0;
      r_out_idx   <= '0;
      r_out_dx    <= '0;
      r_out_dy    <= '0;
      r_out_addr  <= '0;
    end else begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_hit  <= w_enc_hit;
        r_out_idx  <= w_enc_idx;
        r_out_dx   <= w_enc_dx;
        r_out_dy   <= w_enc_dy;
        r_out_addr <= r_s1_addr;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign hit       = r_out_hit;
  assign hit_idx   = r_out_idx;
  assign off_x     = r_out_dx;
  assign off_y     = r_out_dy;
  assign out_addr  = r_out_addr;

endmodule

// File: tb/tb_multi_sprite_hit.sv
// tb/tb_multi_sprite_hit.sv - scoreboard bench for multi_sprite_hit
module tb_multi_sprite_hit;
  localparam int H   = 640;
  localparam int V   = 48;
  localparam int N   = 4;
  localparam int SW  = 24;
  localparam int SH  = 24;
  localparam int CW  = 10;
  localparam int AW  = 19;
  localparam int IW  = 2;
  localparam int OXW = 5;
  localparam int OYW = 5;

  logic          m_clk = 1'b0;
  logic          reset = 1'b1;
  logic          pix_valid = 1'b0, pix_start = 1'b0, cfg_we = 1'b0, cfg_en = 1'b0;
  logic [IW-1:0] cfg_idx = '0;
  logic [CW-1:0] cfg_x = '0, cfg_y = '0;
  logic          out_valid, hit;
  logic [IW-1:0] hit_idx;
  logic [OXW-1:0] off_x;
  logic [OYW-1:0] off_y;
  logic [AW-1:0] out_addr;

  multi_sprite_hit #(
    .H_RES(H), .V_RES(V), .NUM_SPRITES(N), .SPRITE_W(SW), .SPRITE_H(SH),
    .COORD_W(CW), .ADDR_W(AW)
  ) dut (
    .m_clk(m_clk), .reset(reset), .pix_valid(pix_valid), .pix_start(pix_start),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_en(cfg_en),
    .out_valid(out_valid), .hit(hit), .hit_idx(hit_idx), .off_x(off_x), .off_y(off_y),
    .out_addr(out_addr)
  );

  always #5 m_clk = ~m_clk;

  typedef struct packed {
    logic           hit;
    logic [IW-1:0]  idx;
    logic [OXW-1:0] ox;
    logic [OYW-1:0] oy;
    logic [AW-1:0]  addr;
  } res_t;

  typedef struct {
    res_t r;
    int   due;
  } exp_t;

  exp_t q[$];
  res_t dq[$];
  res_t last;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  int bx, by, baddr;
  int pend_x[N], pend_y[N], act_x[N], act_y[N];
  bit pend_en[N], act_en[N];

  always @(posedge m_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic res_t model(input int x, input int y, input int a);
    res_t r;
    r = '0;
    r.addr = AW'(a);
    for (int i = N - 1; i >= 0; i--) begin
      if (act_en[i] && x >= act_x[i] && x <= act_x[i] + SW - 1 &&
          y >= act_y[i] && y <= act_y[i] + SH - 1) begin
        r.hit = 1'b1;
        r.idx = IW'(i);
        r.ox  = OXW'(x - act_x[i]);
        r.oy  = OYW'(y - act_y[i]);
      end
    end
    return r;
  endfunction

  task automatic model_clear();
    bx = 0; by = 0; baddr = 0;
    for (int i = 0; i < N; i++) begin
      pend_x[i] = 0; pend_y[i] = 0; pend_en[i] = 0;
      act_x[i] = 0;  act_y[i] = 0;  act_en[i] = 0;
    end
  endtask

  task automatic drive(input bit v, input bit st, input bit we, input int idx,
                       input int cx, input int cy, input bit en);
    exp_t e;
    pix_valid = v; pix_start = st; cfg_we = we; cfg_idx = IW'(idx);
    cfg_x = CW'(cx); cfg_y = CW'(cy); cfg_en = en;
    if (we && idx < N) begin
      pend_x[idx] = cx; pend_y[idx] = cy; pend_en[idx] = en;
    end
    if (v) begin
      if (st) begin
        for (int i = 0; i < N; i++) begin
          act_x[i] = pend_x[i]; act_y[i] = pend_y[i]; act_en[i] = pend_en[i];
        end
        bx = 0; by = 0; baddr = 0;
      end
      e.r = model(bx, by, baddr);
      e.due = cyc + 2;
      q.push_back(e);
      bx++; baddr++;
      if (bx == H) begin
        bx = 0; by++;
        if (by == V) begin by = 0; baddr = 0; end
      end
    end
    @(posedge m_clk); #1;
    pix_valid = 1'b0; pix_start = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic cfg(input int idx, input int x, input int y, input bit en);
    drive(1'b0, 1'b0, 1'b1, idx, x, y, en);
  endtask

  task automatic start_frame();
    drive(1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic dir(input int a, input bit h, input int idx, input int ox, input int oy);
    res_t r;
    r.hit = h; r.idx = IW'(idx); r.ox = OXW'(ox); r.oy = OYW'(oy); r.addr = AW'(a);
    dq.push_back(r);
  endtask

  task automatic do_reset();
    mon_en = 1'b0; reset = 1'b1;
    pix_valid = 1'b0; pix_start = 1'b0; cfg_we = 1'b0;
    @(posedge m_clk); #1;
    q.delete();
    last = '0;
    model_clear();
    mon_en = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_hit", 32'(hit), 0);
    chk("rst_hit_idx", 32'(hit_idx), 0);
    chk("rst_off_x", 32'(off_x), 0);
    chk("rst_off_y", 32'(off_y), 0);
    chk("rst_out_addr", 32'(out_addr), 0);
    @(posedge m_clk); #1;
    reset = 1'b0;
  endtask

  always @(negedge m_clk) begin
    exp_t e;
    res_t d;
    if (mon_en) begin
      if (q.size() > 0 && q[0].due < cyc) begin
        chk("result_late", 32'(cyc), 32'(q[0].due));
        void'(q.pop_front());
      end
      if (out_valid) begin
        chk("valid_expected", 32'(q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("latency", 32'(cyc), 32'(e.due));
          chk("hit", 32'(hit), 32'(e.r.hit));
          chk("hit_idx", 32'(hit_idx), 32'(e.r.idx));
          chk("off_x", 32'(off_x), 32'(e.r.ox));
          chk("off_y", 32'(off_y), 32'(e.r.oy));
          chk("out_addr", 32'(out_addr), 32'(e.r.addr));
          last = e.r;
          if (dq.size() > 0 && out_addr === dq[0].addr) begin
            d = dq.pop_front();
            chk("dir_hit", 32'(hit), 32'(d.hit));
            chk("dir_idx", 32'(hit_idx), 32'(d.idx));
            chk("dir_off_x", 32'(off_x), 32'(d.ox));
            chk("dir_off_y", 32'(off_y), 32'(d.oy));
          end
        end
      end else begin
        chk("hold_hit", 32'(hit), 32'(last.hit));
        chk("hold_idx", 32'(hit_idx), 32'(last.idx));
        chk("hold_off_x", 32'(off_x), 32'(last.ox));
        chk("hold_off_y", 32'(off_y), 32'(last.oy));
        chk("hold_addr", 32'(out_addr), 32'(last.addr));
      end
    end
  end

  initial begin
    model_clear();
    do_reset();

    // Basic hit/miss with a 3-cycle bubble early in line 0
    cfg(0, 10, 20, 1'b1);
    dir(12810, 1'b1, 0, 0, 0);
    dir(12834, 1'b0, 0, 0, 0);
    dir(27553, 1'b1, 0, 23, 23);
    dir(28170, 1'b0, 0, 0, 0);
    start_frame();
    run(100);
    idle(3);
    run(28070);
    idle(3);

    // Priority between overlapping sprites
    cfg(0, 0, 0, 1'b0);
    cfg(1, 0, 0, 1'b1);
    cfg(2, 5, 5, 1'b1);
    dir(3846, 1'b1, 1, 6, 6);
    dir(16025, 1'b1, 2, 20, 20);
    start_frame();
    run(16030);

    // Bottom-right clipping and frame wrap
    cfg(1, 0, 0, 1'b0);
    cfg(2, 0, 0, 1'b0);
    cfg(3, 630, 38, 1'b1);
    dir(25605, 1'b0, 0, 0, 0);
    dir(30719, 1'b1, 3, 9, 9);
    dir(0, 1'b0, 0, 0, 0);
    start_frame();
    run(30719);
    run(1);
    idle(3);

    // Shadow commit: mid-frame write waits for next frame start
    cfg(3, 0, 0, 1'b0);
    cfg(0, 10, 0, 1'b1);
    dir(10, 1'b1, 0, 0, 0);
    dir(650, 1'b1, 0, 0, 1);
    dir(740, 1'b0, 0, 0, 0);
    start_frame();
    run(49);
    drive(1'b1, 1'b0, 1'b1, 0, 100, 0, 1'b1);
    run(700);
    dir(650, 1'b0, 0, 0, 0);
    dir(740, 1'b1, 0, 0, 1);
    start_frame();
    run(745);
    dir(0, 1'b1, 0, 0, 0);
    dir(23, 1'b1, 0, 23, 0);
    dir(100, 1'b0, 0, 0, 0);
    drive(1'b1, 1'b1, 1'b1, 0, 0, 0, 1'b1);
    run(120);

    // Reset with pixels in flight, then resume without pix_start
    run(3);
    do_reset();
    dir(0, 1'b0, 0, 0, 0);
    dir(5, 1'b0, 0, 0, 0);
    run(30);
    idle(4);

    chk("scoreboard_drained", 32'(q.size()), 0);
    chk("directed_drained", 32'(dq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
